queue_receiver_module: RTL and testbench

Receiving end of a KPN channel: accepts the 16-bit token stream a source queue drives on `output_1`/`wr` and buffers it in a 2**FIFO_ELEMENTS-entry FIFO for the consuming process node. The consumer pops tokens with `rd` and receives registered data plus a valid pulse. Status outputs `empty`, `full`, `count` and a sticky `overflow` let the network controller detect back-pressure violations, since the source has no stall input.

---
 rtl/queue_receiver_module.sv | 82 ++++++++
 tb/tb_queue_receiver_module.sv | 119 +++++++++++
 2 files changed

// File: rtl/queue_receiver_module.sv
// Receive-side FIFO of a KPN channel: absorbs a non-stallable token stream and
// hands tokens to the consumer as registered data with a one-cycle valid pulse.
module queue_receiver_module #(
   parameter int BITS_NUMBER   = 16,
   parameter int FIFO_ELEMENTS = 5
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr,
   input  logic [BITS_NUMBER-1:0]   input_1,
   input  logic                     rd,
   output logic [BITS_NUMBER-1:0]   output_1,
   output logic                     valid_out,
   output logic                     empty,
   output logic                     full,
   output logic [FIFO_ELEMENTS:0]   count,
   output logic                     overflow
);

   localparam int DEPTH = 2**FIFO_ELEMENTS;
   localparam logic [FIFO_ELEMENTS:0] FULL_CNT = {1'b1, {FIFO_ELEMENTS{1'b0}}};

   logic [BITS_NUMBER-1:0]   mem_q [DEPTH];
   logic [FIFO_ELEMENTS-1:0] w_ptr_q, w_ptr_d, r_ptr_q, r_ptr_d;
   logic [FIFO_ELEMENTS:0]   count_q, count_d;
   logic                     empty_q, full_q, valid_q, ovf_q, ovf_d;
   logic [BITS_NUMBER-1:0]   out_q;
   logic                     wr_en, rd_en;

   // A pop frees a slot in the same cycle, so a write is still taken when full.
   assign wr_en = wr && (!full_q || rd);
   assign rd_en = rd && !empty_q;

   always_comb begin
      w_ptr_d = w_ptr_q;
      r_ptr_d = r_ptr_q;
      count_d = count_q;
      ovf_d   = ovf_q | (wr && full_q && !rd);
      if (wr_en) w_ptr_d = w_ptr_q + 1'b1;
      if (rd_en) r_ptr_d = r_ptr_q + 1'b1;
      case ({wr_en, rd_en})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_ptr_q <= '0;
         r_ptr_q <= '0;
         count_q <= '0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
         out_q   <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         w_ptr_q <= w_ptr_d;
         r_ptr_q <= r_ptr_d;
         count_q <= count_d;
         empty_q <= (count_d == '0);
         full_q  <= (count_d == FULL_CNT);
         valid_q <= rd_en;
         ovf_q   <= ovf_d;
         if (rd_en) out_q <= mem_q[r_ptr_q];
      end
   end

   // Storage carries no reset; only control state does.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[w_ptr_q] <= input_1;
   end

   assign output_1  = out_q;
   assign valid_out = valid_q;
   assign empty     = empty_q;
   assign full      = full_q;
   assign count     = count_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_queue_receiver_module.sv
// Directed bench for queue_receiver_module: a token queue holds what the
// consumer should see next, and every cycle the outputs are compared to it.
module tb_queue_receiver_module;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr, rd;
   logic [15:0] input_1;
   logic [15:0] output_1;
   logic        valid_out, empty, full, overflow;
   logic [5:0]  count;

   int          checks = 0;
   int          failures = 0;
   logic [15:0] sb[$];
   logic [15:0] last_out;
   logic        exp_ovf;

   queue_receiver_module #(.BITS_NUMBER(16), .FIFO_ELEMENTS(5)) dut (
      .clk(clk), .rst_n(rst_n), .wr(wr), .input_1(input_1), .rd(rd),
      .output_1(output_1), .valid_out(valid_out), .empty(empty), .full(full),
      .count(count), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_state(input string tag, input logic exp_v);
      chk({tag, ".valid"}, 32'(valid_out), 32'(exp_v));
      chk({tag, ".data"},  32'(output_1),  32'(last_out));
      chk({tag, ".count"}, 32'(count),     32'(sb.size()));
      chk({tag, ".empty"}, 32'(empty),     32'(sb.size() == 0));
      chk({tag, ".full"},  32'(full),      32'(sb.size() == 32));
      chk({tag, ".ovf"},   32'(overflow),  32'(exp_ovf));
   endtask

   // One clock: drive, update the expectation, sample 1 time unit after the edge.
   task automatic step(input string tag, input logic w, input logic [15:0] d, input logic r);
      int   n;
      logic rd_ok, wr_ok;
      wr = w; input_1 = d; rd = r;
      n = sb.size();
      rd_ok = r && (n > 0);
      wr_ok = w && ((n < 32) || r);
      if (w && n == 32 && !r) exp_ovf = 1'b1;
      if (rd_ok) last_out = sb.pop_front();
      if (wr_ok) sb.push_back(d);
      @(posedge clk); #1;
      chk_state(tag, rd_ok);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      wr = 1'b0; rd = 1'b0; input_1 = '0;
      sb.delete(); last_out = '0; exp_ovf = 1'b0;
      #12;
      chk_state("reset", 1'b0);
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      rst_n = 1'b0; wr = 1'b0; rd = 1'b0; input_1 = '0;
      sb.delete(); last_out = '0; exp_ovf = 1'b0;
      #1;
      do_reset();

      // ordered transfer
      for (int i = 1; i <= 4; i++) step("ord_wr", 1'b1, 16'(i), 1'b0);
      for (int i = 0; i < 4; i++) step("ord_rd", 1'b0, 16'h0, 1'b1);

      // async reset mid-cycle with three tokens held and a nonzero output
      for (int i = 0; i < 4; i++) step("pre_rst_wr", 1'b1, 16'h0A00 + 16'(i), 1'b0);
      step("pre_rst_rd", 1'b0, 16'h0, 1'b1);
      #3;
      rst_n = 1'b0;
      sb.delete(); last_out = '0; exp_ovf = 1'b0;
      #1;
      chk_state("async_rst", 1'b0);
      #3;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk_state("post_rst", 1'b0);

      // fill, overflow, drain
      for (int i = 0; i < 32; i++) step("fill_wr", 1'b1, 16'h1100 + 16'(i), 1'b0);
      step("ovf_wr", 1'b1, 16'hDEAD, 1'b0);
      for (int i = 0; i < 32; i++) step("drain_rd", 1'b0, 16'h0, 1'b1);
      step("rd_empty", 1'b0, 16'h0, 1'b1);

      // full with simultaneous rd+wr
      do_reset();
      for (int i = 0; i < 32; i++) step("fill2_wr", 1'b1, 16'h2200 + 16'(i), 1'b0);
      step("full_rdwr", 1'b1, 16'hBEEF, 1'b1);
      for (int i = 0; i < 32; i++) step("drain2_rd", 1'b0, 16'h0, 1'b1);

      // empty boundary
      step("rd_empty2", 1'b0, 16'h0, 1'b1);
      step("empty_rdwr", 1'b1, 16'h00AA, 1'b1);
      step("aa_rd", 1'b0, 16'h0, 1'b1);

      // streaming across pointer wrap
      step("wrap_first", 1'b1, 16'h3000, 1'b0);
      for (int i = 1; i < 40; i++) step("wrap_pair", 1'b1, 16'h3000 + 16'(i), 1'b1);
      step("wrap_last", 1'b0, 16'h0, 1'b1);
      step("wrap_idle", 1'b0, 16'h0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
